// File: rtl/lif_pkg.sv
// lif_pkg: shared constants, state encoding and frame helpers for the LIF parameter loader
package lif_pkg;
  localparam int PARAM_W = 8;
  localparam logic [PARAM_W-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [PARAM_W-1:0] CHK_SEED = 8'h5A;
  localparam int IDX_THRESH = 3;
  localparam int IDX_LEAK = 2;
  localparam int IDX_WA = 1;
  localparam int IDX_WB = 0;
  typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, CHECK, COMMIT} ld_state_e;
  function automatic logic [PARAM_W-1:0] pay_byte(input logic [4*PARAM_W-1:0] p, input int idx);
    return p[idx*PARAM_W +: PARAM_W];
  endfunction
  function automatic logic [PARAM_W-1:0] frame_chk(input logic [4*PARAM_W-1:0] p);
    return p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0] ^ CHK_SEED;
  endfunction
endpackage

// File: rtl/lif_frame_shifter.sv
// lif_frame_shifter: 8-bit serial window with bit counter and byte boundary flag
module lif_frame_shifter
  import lif_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               shift,
  input  logic               clr,
  input  logic               din,
  output logic [PARAM_W-1:0] win_n,
  output logic [6:0]         cnt,
  output logic               byte_done
);
  logic [PARAM_W-1:0] win;
  assign win_n = {win[PARAM_W-2:0], din};
  assign byte_done = cnt[2:0] == 3'd7;
  always_ff @(posedge clk)
    if (rst) begin
      win <= '0;
      cnt <= '0;
    end else if (ena) begin
      if (shift) win <= win_n;
      cnt <= clr ? 7'd0 : shift ? cnt + 7'd1 : cnt;
    end
endmodule

// File: rtl/lif_param_loader.sv
// lif_param_loader: deserialises and checks parameter frames, committing them atomically to shadow registers
module lif_param_loader
  import lif_pkg::*;
#(
  parameter logic [PARAM_W-1:0] THRESH_DEF = 8'd64,
  parameter logic [PARAM_W-1:0] LEAK_DEF = 8'd2,
  parameter logic [PARAM_W-1:0] WA_DEF = 8'd1,
  parameter logic [PARAM_W-1:0] WB_DEF = 8'd1,
  parameter int SYNC_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               load_mode,
  input  logic               serial_data,
  output logic [PARAM_W-1:0] threshold,
  output logic [PARAM_W-1:0] leak_rate,
  output logic [PARAM_W-1:0] weight_a,
  output logic [PARAM_W-1:0] weight_b,
  output logic               params_ready,
  output logic               param_update,
  output logic               frame_error,
  output logic               busy
);
  ld_state_e state, state_n;
  logic [4*PARAM_W-1:0] payload;
  logic [PARAM_W-1:0] win_n;
  logic [6:0] cnt, nxt;
  logic byte_done, shift, clr, err, commit, slot, drop;
  assign slot = ena & load_mode;
  assign drop = ena & ~load_mode;
  assign nxt = cnt + 7'd1;
  assign clr = (state_n != state) && (state_n != SYNC);
  assign busy = state != IDLE;
  lif_frame_shifter u_shift (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .shift(shift),
    .clr(clr),
    .din(serial_data),
    .win_n(win_n),
    .cnt(cnt),
    .byte_done(byte_done)
  );
  always_comb begin
    state_n = state;
    shift = 1'b0;
    err = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE: if (slot) begin
        shift = 1'b1;
        state_n = SYNC;
      end
      SYNC: if (drop) state_n = IDLE;
      else if (slot) begin
        shift = 1'b1;
        if (nxt >= 7'd8 && win_n == SYNC_BYTE) state_n = PAYLOAD;
        else if (nxt == 7'(SYNC_TIMEOUT)) begin
          err = 1'b1;
          state_n = IDLE;
        end
      end
      PAYLOAD: if (drop) begin
        err = 1'b1;
        state_n = IDLE;
      end else if (slot) begin
        shift = 1'b1;
        if (nxt == 7'd32) state_n = CHECK;
      end
      CHECK: if (drop) begin
        err = 1'b1;
        state_n = IDLE;
      end else if (slot) begin
        shift = 1'b1;
        if (byte_done) begin
          err = win_n != frame_chk(payload);
          state_n = err ? IDLE : COMMIT;
        end
      end
      COMMIT: if (ena) begin
        commit = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      payload <= '0;
      threshold <= THRESH_DEF;
      leak_rate <= LEAK_DEF;
      weight_a <= WA_DEF;
      weight_b <= WB_DEF;
      params_ready <= 1'b0;
      param_update <= 1'b0;
      frame_error <= 1'b0;
    end else if (ena) begin
      state <= state_n;
      frame_error <= err;
      param_update <= commit;
      if (state == PAYLOAD && shift) payload <= {payload[4*PARAM_W-2:0], serial_data};
      if (commit) begin
        threshold <= pay_byte(payload, IDX_THRESH);
        leak_rate <= pay_byte(payload, IDX_LEAK);
        weight_a <= pay_byte(payload, IDX_WA);
        weight_b <= pay_byte(payload, IDX_WB);
        params_ready <= 1'b1;
      end
    end
endmodule
